instruction_fetch_stage: RTL and testbench

//   IF stage of the RISC-V pipeline: owns the PC, drives the word address into instruction memory,

---
 rtl/instruction_fetch_stage_pkg.sv | 28 ++
 rtl/instruction_fetch_stage_if_id_register.sv | 60 ++++++
 rtl/instruction_fetch_stage.sv | 167 ++++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: width constants, the
// fetch FSM state encoding, the canonical NOP and a saturating counter helper.
package riscv_pipeline_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // addi x0,x0,0 -- used as the IF/ID bubble
    localparam logic [ILEN-1:0] IF_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register. flush loads a bubble (pc 0, NOP, invalid) and
// wins over capture; capture loads a fetched instruction; otherwise hold.
module if_id_register
    import riscv_pipeline_pkg::*;
#(
    parameter logic [ILEN-1:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            capture,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_in,
    input  logic [ILEN-1:0] instr_in,
    output logic [XLEN-1:0] if_id_pc,
    output logic [ILEN-1:0] if_id_instr,
    output logic            if_id_valid
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;

    // Next-state selection: bubble, load or hold
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush) begin
            pc_d    = 64'h0;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (capture) begin
            pc_d    = pc_in;
            instr_d = instr_in;
            valid_d = 1'b1;
        end else begin
            pc_d    = pc_q;
            instr_d = instr_q;
            valid_d = valid_q;
        end
    end

    // Register the IF/ID contents; reset leaves a bubble
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= 64'h0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign if_id_pc    = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_valid = valid_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, presents it to instruction memory and feeds IF/ID.
// Priority per cycle once running: redirect > stall > advance. An all-zero
// fetch halts the stage until a redirect proves it was wrong-path.
// Optional: define IF_PERF_COUNTERS_EN to add saturating fetch/stall/flush
// counters on extra output ports.
module instruction_fetch_stage
    import riscv_pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 64'h0,
    parameter logic [ILEN-1:0] NOP_INSTR    = IF_NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic [ILEN-1:0] instruction_in,
    output logic [XLEN-1:0] inst_address,
    output logic [XLEN-1:0] if_id_pc,
    output logic [ILEN-1:0] if_id_instr,
    output logic            if_id_valid,
    output logic            halted
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            halted_q, halted_d;
    logic            capture_s;
    logic            bubble_s;
    logic            zero_fetch_s;
    logic [XLEN-1:0] target_pc_s;
    logic [1:0]      unused_redirect_lsbs_s;

    assign zero_fetch_s           = (instruction_in == 32'h0000_0000);
    assign target_pc_s            = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs_s = redirect_pc[1:0];

    // Fetch FSM next state, PC update and IF/ID control
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        capture_s = 1'b0;
        bubble_s  = 1'b0;
        case (state_q)
            FS_BOOT: begin
                // One settling cycle after reset: nothing fetched, PC held
                state_d = FS_RUN;
            end
            FS_RUN: begin
                if (redirect) begin
                    pc_d     = target_pc_s;
                    bubble_s = 1'b1;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (zero_fetch_s) begin
                    state_d  = FS_HALT;
                    bubble_s = 1'b1;
                end else begin
                    pc_d      = pc_q + 64'd4;
                    capture_s = 1'b1;
                end
            end
            FS_HALT: begin
                if (redirect) begin
                    state_d  = FS_RUN;
                    pc_d     = target_pc_s;
                    bubble_s = 1'b1;
                end else if (stall) begin
                    pc_d = pc_q;
                end else begin
                    bubble_s = 1'b1;
                end
            end
            default: begin
                state_d  = FS_BOOT;
                pc_d     = RESET_VECTOR;
                bubble_s = 1'b1;
            end
        endcase
        halted_d = (state_d == FS_HALT);
    end

    // State, PC and halt flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= FS_BOOT;
            pc_q     <= RESET_VECTOR;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    assign inst_address = pc_q;
    assign halted       = halted_q;

    if_id_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk         (clk),
        .reset_n     (reset_n),
        .capture     (capture_s),
        .flush       (bubble_s),
        .pc_in       (pc_q),
        .instr_in    (instruction_in),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid)
    );

`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic        active_s;

    assign active_s = (state_q != FS_BOOT);

    // Counter events: captures, plain stall cycles, redirects
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (capture_s) begin
            fetch_cnt_d = sat_inc32(fetch_cnt_q);
        end else begin
            fetch_cnt_d = fetch_cnt_q;
        end
        if (active_s && stall && !redirect) begin
            stall_cnt_d = sat_inc32(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (active_s && redirect) begin
            flush_cnt_d = sat_inc32(flush_cnt_q);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed scenarios plus a
// randomized run against a transaction-level reference model.
// Define IF_PERF_COUNTERS_EN to also exercise the performance counters.
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [31:0] instruction_in;
    logic [63:0] inst_address;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;
`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // 256-word instruction memory, indexed by address bits [9:2]
    logic [31:0] mem_arr [0:255];
    assign instruction_in = mem_arr[inst_address[9:2]];

    // Reference model state
    logic        m_booted;
    logic        m_halted;
    logic [63:0] m_pc;
    logic [63:0] m_ifpc;
    logic [31:0] m_ifinstr;
    logic        m_valid;
    int unsigned m_fetch, m_stall, m_flush;

    logic [161:0] got, exp;

    always #5 clk = ~clk;

    instruction_fetch_stage dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instruction_in (instruction_in),
        .inst_address   (inst_address),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid),
        .halted         (halted)
`ifdef IF_PERF_COUNTERS_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    assign got = {inst_address, if_id_pc, if_id_instr, if_id_valid, halted};

    task automatic model_reset();
        m_booted = 1'b0; m_halted = 1'b0; m_pc = 64'h0;
        m_ifpc = 64'h0; m_ifinstr = NOP; m_valid = 1'b0;
        m_fetch = 0; m_stall = 0; m_flush = 0;
    endtask

    function automatic int unsigned sat(input int unsigned v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    // One clock of architectural behaviour, written from the stage's rules
    task automatic model_edge(input logic st, input logic rd, input logic [63:0] rpc);
        logic [31:0] word;
        if (!m_booted) begin
            m_booted = 1'b1;
            return;
        end
        word = mem_arr[m_pc[9:2]];
        if (rd) begin
            m_pc = {rpc[63:2], 2'b00};
            m_ifpc = 64'h0; m_ifinstr = NOP; m_valid = 1'b0;
            m_halted = 1'b0;
            m_flush = sat(m_flush);
        end else if (st) begin
            m_stall = sat(m_stall);
        end else if (m_halted || word == 32'h0) begin
            m_halted = 1'b1;
            m_ifpc = 64'h0; m_ifinstr = NOP; m_valid = 1'b0;
        end else begin
            m_ifpc = m_pc; m_ifinstr = word; m_valid = 1'b1;
            m_pc = m_pc + 64'd4;
            m_fetch = sat(m_fetch);
        end
    endtask

    // Drive inputs at the falling edge, clock once, return at the next falling edge
    task automatic cycle(input logic st, input logic rd, input logic [63:0] rpc);
        stall = st; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        model_edge(st, rd, rpc);
        @(negedge clk);
    endtask

    task automatic fill_mem(input int zero_one_in);
        for (int i = 0; i < 256; i++) begin
            if (zero_one_in > 0 && $urandom_range(0, zero_one_in - 1) == 0) begin
                mem_arr[i] = 32'h0;
            end else begin
                mem_arr[i] = $urandom | 32'h1;
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 64'h0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        fill_mem(0);
        mem_arr[0] = 32'h0040_0293;
        do_reset();
        exp = {64'h0, 64'h0, NOP, 1'b0, 1'b0};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL reset_state: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_boot_fetch();
        cycle(1'b0, 1'b0, 64'h0);
        exp = {64'h0, 64'h0, NOP, 1'b0, 1'b0};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL boot_cycle: got %h expected %h", got, exp);
        end
        cycle(1'b0, 1'b0, 64'h0);
        exp = {64'h4, 64'h0, 32'h0040_0293, 1'b1, 1'b0};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL first_fetch: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_stall();
        cycle(1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 64'h0);
            exp = {64'h8, 64'h4, mem_arr[1], 1'b1, 1'b0};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL stall_hold_%0d: got %h expected %h", i, got, exp);
            end
        end
        cycle(1'b0, 1'b0, 64'h0);
        exp = {64'hC, 64'h8, mem_arr[2], 1'b1, 1'b0};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL stall_release: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_redirect_during_stall();
        cycle(1'b1, 1'b1, 64'h3A);
        exp = {64'h38, 64'h0, NOP, 1'b0, 1'b0};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL redirect_stall: got %h expected %h", got, exp);
        end
        cycle(1'b0, 1'b0, 64'h0);
        exp = {64'h3C, 64'h38, mem_arr[14], 1'b1, 1'b0};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL redirect_resume: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_halt();
        logic [31:0] saved;
        saved = mem_arr[4];
        mem_arr[4] = 32'h0;
        cycle(1'b0, 1'b1, 64'h10);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 64'h0);
            exp = {64'h10, 64'h0, NOP, 1'b0, 1'b1};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL halt_hold_%0d: got %h expected %h", i, got, exp);
            end
        end
        cycle(1'b0, 1'b1, 64'h40);
        exp = {64'h40, 64'h0, NOP, 1'b0, 1'b0};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL halt_redirect: got %h expected %h", got, exp);
        end
        cycle(1'b0, 1'b0, 64'h0);
        exp = {64'h44, 64'h40, mem_arr[16], 1'b1, 1'b0};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL halt_resume: got %h expected %h", got, exp);
        end
        mem_arr[4] = saved;
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        exp = {64'hFFFF_FFFF_FFFF_FFFC, 64'h0, NOP, 1'b0, 1'b0};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL wrap_align: got %h expected %h", got, exp);
        end
        cycle(1'b0, 1'b0, 64'h0);
        exp = {64'h0, 64'hFFFF_FFFF_FFFF_FFFC, mem_arr[255], 1'b1, 1'b0};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL wrap_pc: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 1'b0, 64'h0);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 64'h100;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        exp = {64'h0, 64'h0, NOP, 1'b0, 1'b0};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL async_reset: got %h expected %h", got, exp);
        end
`ifdef IF_PERF_COUNTERS_EN
        n_cmp++;
        if ({perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt} !== 96'h0) begin
            n_bad++;
            $display("FAIL async_reset_perf: got %0d/%0d/%0d expected 0/0/0",
                     perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt);
        end
`endif
        @(negedge clk);
        stall = 1'b0; redirect = 1'b0; redirect_pc = 64'h0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

`ifdef IF_PERF_COUNTERS_EN
    task automatic test_perf_counters();
        fill_mem(0);
        do_reset();
        cycle(1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 64'h0);
        cycle(1'b0, 1'b1, 64'h80);
        n_cmp++;
        if ({perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt} !== {32'd5, 32'd2, 32'd1}) begin
            n_bad++;
            $display("FAIL perf_counts: got %0d/%0d/%0d expected 5/2/1",
                     perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt);
        end
    endtask
`endif

    task automatic test_random();
        logic        st, rd;
        logic [63:0] rpc;
        fill_mem(12);
        do_reset();
        for (int i = 0; i < 400; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            rpc = {$urandom, $urandom};
            cycle(st, rd, rpc);
            exp = {m_pc, m_ifpc, m_ifinstr, m_valid, m_halted};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL random_cycle_%0d: got %h expected %h", i, got, exp);
            end
`ifdef IF_PERF_COUNTERS_EN
            n_cmp++;
            if ({perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt} !== {m_fetch[31:0], m_stall[31:0], m_flush[31:0]}) begin
                n_bad++;
                $display("FAIL random_perf_%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", i,
                         perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt, m_fetch, m_stall, m_flush);
            end
`endif
        end
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 64'h0;
        test_reset();
        test_boot_fetch();
        test_stall();
        test_redirect_during_stall();
        test_halt();
        test_wrap();
        test_async_reset();
`ifdef IF_PERF_COUNTERS_EN
        test_perf_counters();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
